// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one combinational ALU between two requesters. Each cycle it picks one
// request using round-robin priority and drives that request onto the ALU
// inputs. The ALU result is captured into a one-entry response register that
// uses valid/ready backpressure. The block also keeps the architectural zero
// flag, which only CMP updates.
//
// Optional feature: define ALU_SHARE_STATS_EN to add saturating 16-bit
// counters (grant0_cnt, grant1_cnt, stall_cnt).
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   reqN_valid/reqN_ready   request handshake for port N (ready is combinational)
//   reqN_op/reqN_a/reqN_b   opcode and operands for port N
//   alu_srca/srcb/op        operands and opcode driven to the shared ALU
//   alu_result/alu_flags    ALU outputs (only flags[2] = Z is used, for CMP)
//   rsp_valid/rsp_ready     response handshake
//   rsp_id                  port that issued the held response
//   rsp_result/we/err       captured result, write-back enable, illegal-op flag
//   z_flag                  architectural zero flag
//   grant0/1_cnt, stall_cnt statistics (ALU_SHARE_STATS_EN only)
// -----------------------------------------------------------------------------
module alu_share_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic [31:0] alu_srca,
   output logic [31:0] alu_srcb,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_result,
   output logic        rsp_we,
   output logic        rsp_err,
   output logic        z_flag
`ifdef ALU_SHARE_STATS_EN
   ,
   output logic [15:0] grant0_cnt,
   output logic [15:0] grant1_cnt,
   output logic [15:0] stall_cnt
`endif
);

   typedef enum logic [3:0] {
      OP_SUB = 4'b0010,
      OP_ADD = 4'b0100,
      OP_CMP = 4'b1010,
      OP_MOV = 4'b1101
   } op_e;

   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [31:0] r_rsp_result;
   logic        r_rsp_we;
   logic        r_rsp_err;
   logic        r_z_flag;
   logic        r_last;

   logic        w_free;
   logic        w_gnt_vld;
   logic        w_gnt_id;
   logic        w_op_legal;
   logic        w_op_cmp;

   // The slot is free when it is empty or is being drained in this cycle.
   assign w_free = !r_rsp_valid || rsp_ready;

   // NOTE: every signal in an always_comb gets a default first, so no path
   // through the block can leave a value unassigned and infer a latch.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 1'b0;
      // Nothing is accepted during the reset cycle.
      if (w_free && !reset) begin
         if (req0_valid && req1_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = ~r_last;
         end else if (req0_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = 1'b0;
         end else if (req1_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = 1'b1;
         end
      end
   end

   assign req0_ready = w_gnt_vld && !w_gnt_id;
   assign req1_ready = w_gnt_vld &&  w_gnt_id;

   // With no grant, port 0's fields are passed through. The value is unused,
   // but it is always a real input and never X.
   assign alu_srca = (w_gnt_vld && w_gnt_id) ? req1_a  : req0_a;
   assign alu_srcb = (w_gnt_vld && w_gnt_id) ? req1_b  : req0_b;
   assign alu_op   = (w_gnt_vld && w_gnt_id) ? req1_op : req0_op;

   always_comb begin
      w_op_legal = 1'b0;
      w_op_cmp   = 1'b0;
      case (alu_op)
         OP_SUB, OP_ADD, OP_MOV: w_op_legal = 1'b1;
         OP_CMP: begin
            w_op_legal = 1'b1;
            w_op_cmp   = 1'b1;
         end
         default: w_op_legal = 1'b0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // flop samples the values present before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= 32'd0;
         r_rsp_we     <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_z_flag     <= 1'b0;
         r_last       <= 1'b1;     // port 0 wins the first contention
      end else if (w_gnt_vld) begin
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= w_gnt_id;
         r_last      <= w_gnt_id;
         if (w_op_legal) begin
            r_rsp_result <= alu_result;
            r_rsp_we     <= !w_op_cmp;
            r_rsp_err    <= 1'b0;
            if (w_op_cmp) begin
               r_z_flag <= alu_flags[2];
            end
         end else begin
            r_rsp_result <= 32'd0;
            r_rsp_we     <= 1'b0;
            r_rsp_err    <= 1'b1;
         end
      end else if (rsp_ready) begin
         // Drain with no refill. During a stall the response fields hold.
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_we     = r_rsp_we;
   assign rsp_err    = r_rsp_err;
   assign z_flag     = r_z_flag;

`ifdef ALU_SHARE_STATS_EN
   logic [15:0] r_grant0_cnt;
   logic [15:0] r_grant1_cnt;
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant0_cnt <= 16'd0;
         r_grant1_cnt <= 16'd0;
         r_stall_cnt  <= 16'd0;
      end else begin
         if (req0_ready && r_grant0_cnt != 16'hFFFF) begin
            r_grant0_cnt <= r_grant0_cnt + 16'd1;
         end
         if (req1_ready && r_grant1_cnt != 16'hFFFF) begin
            r_grant1_cnt <= r_grant1_cnt + 16'd1;
         end
         if (r_rsp_valid && !rsp_ready && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign grant0_cnt = r_grant0_cnt;
   assign grant1_cnt = r_grant1_cnt;
   assign stall_cnt  = r_stall_cnt;
`endif

endmodule
